// File: rtl/avg_out_fifo.sv
// rtl/avg_out_fifo.sv - first-word-fall-through output buffer behind avg, never back-pressures its input
// Define AVG_OUT_FIFO_DROP_OLD_EN to overwrite the oldest word on overflow instead of dropping the newest.
module avg_out_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    input  logic          clr_ovf
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          overflow_q;

    logic pop;
    logic push;
    logic ovf_evt;
    logic wr_en;
    logic rd_adv;

    // Flags come only from registered count, so in_valid has no path to them.
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign out_valid = !empty;
    assign out_data  = mem[rd_ptr];

    assign pop     = out_valid && out_ready;
    assign push    = in_valid && (!full || pop);
    assign ovf_evt = in_valid && full && !pop;

`ifdef AVG_OUT_FIFO_DROP_OLD_EN
    // Overwrite the head slot and advance both pointers; count stays at DEPTH.
    assign wr_en  = push || ovf_evt;
    assign rd_adv = pop || ovf_evt;
`else
    assign wr_en  = push;
    assign rd_adv = pop;
`endif

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (push && !pop) begin
            count_q <= count_q + CW'(1);
        end else if (pop && !push) begin
            count_q <= count_q - CW'(1);
        end
    end

    // A new overflow event takes priority over a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (ovf_evt) begin
            overflow_q <= 1'b1;
        end else if (clr_ovf) begin
            overflow_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_avg_out_fifo.sv
// tb/tb_avg_out_fifo.sv - directed self-checking bench for avg_out_fifo
module tb_avg_out_fifo;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        clr_ovf;

    int n_vec;
    int n_err;

    avg_out_fifo #(.DW(16), .DEPTH(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        #2;
        n_vec++;
        if ({out_valid, empty, full, count, overflow} !== {1'b0, 1'b1, 1'b0, 5'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: got v=%b e=%b f=%b c=%0d o=%b, want v=0 e=1 f=0 c=0 o=0",
                     out_valid, empty, full, count, overflow);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_push5();
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i);
            tick();
        end
        in_valid = 1'b0;
        n_vec++;
        if (count !== 5'd5 || out_data !== 16'h0001 || empty !== 1'b0 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL push5: got c=%0d d=%h e=%b v=%b, want c=5 d=0001 e=0 v=1",
                     count, out_data, empty, out_valid);
        end
    endtask

    task automatic test_pop5();
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            n_vec++;
            if (out_data !== 16'(i) || out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL pop5[%0d]: got d=%h v=%b, want d=%h v=1", i, out_data, out_valid, 16'(i));
            end
            tick();
        end
        out_ready = 1'b0;
        n_vec++;
        if (empty !== 1'b1 || count !== 5'd0) begin
            n_err++;
            $display("FAIL pop5_empty: got e=%b c=%0d, want e=1 c=0", empty, count);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] exp;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i);
            tick();
        end
        n_vec++;
        if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL fill16: got f=%b c=%0d o=%b, want f=1 c=16 o=0", full, count, overflow);
        end
        in_data = 16'h00AA;
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_set: got f=%b c=%0d o=%b, want f=1 c=16 o=1", full, count, overflow);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
`ifdef AVG_OUT_FIFO_DROP_OLD_EN
            exp = (i == 15) ? 16'h00AA : 16'(i + 1);
`else
            exp = 16'(i);
`endif
            n_vec++;
            if (out_data !== exp || out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL ovf_drain[%0d]: got d=%h v=%b, want d=%h v=1", i, out_data, out_valid, exp);
            end
            tick();
        end
        out_ready = 1'b0;
        n_vec++;
        if (empty !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_drain_empty: got e=%b, want 1", empty);
        end
    endtask

    task automatic test_full_push_pop();
        logic [15:0] exp;
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        n_vec++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL clr_ovf: got o=%b, want 0", overflow);
        end
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i);
            tick();
        end
        in_data   = 16'h1234;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (overflow !== 1'b0 || count !== 5'd16 || full !== 1'b1) begin
            n_err++;
            $display("FAIL full_push_pop: got o=%b c=%0d f=%b, want o=0 c=16 f=1", overflow, count, full);
        end
        for (int i = 0; i < 16; i++) begin
            exp = (i == 15) ? 16'h1234 : 16'(i + 1);
            n_vec++;
            if (out_data !== exp) begin
                n_err++;
                $display("FAIL fpp_drain[%0d]: got d=%h, want d=%h", i, out_data, exp);
            end
            tick();
        end
        out_ready = 1'b0;
        n_vec++;
        if (empty !== 1'b1) begin
            n_err++;
            $display("FAIL fpp_empty: got e=%b, want 1", empty);
        end
    endtask

    task automatic test_back_to_back();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) begin
                n_vec++;
                if (out_data !== 16'(16'h0100 + i - 1) || out_valid !== 1'b1 || count !== 5'd1) begin
                    n_err++;
                    $display("FAIL stream[%0d]: got d=%h v=%b c=%0d, want d=%h v=1 c=1",
                             i, out_data, out_valid, count, 16'(16'h0100 + i - 1));
                end
            end
            in_data = 16'(16'h0100 + i);
            tick();
        end
        in_valid = 1'b0;
        n_vec++;
        if (out_data !== 16'h0127 || count !== 5'd1) begin
            n_err++;
            $display("FAIL stream_last: got d=%h c=%0d, want d=0127 c=1", out_data, count);
        end
        tick();
        out_ready = 1'b0;
        n_vec++;
        if (empty !== 1'b1 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL stream_end: got e=%b o=%b, want e=1 o=0", empty, overflow);
        end
    endtask

    task automatic test_clr_collision();
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(16'h0200 + i);
            tick();
        end
        in_data = 16'h0077;
        tick();
        n_vec++;
        if (overflow !== 1'b1) begin
            n_err++;
            $display("FAIL coll_set: got o=%b, want 1", overflow);
        end
        in_data = 16'h0088;
        clr_ovf = 1'b1;
        tick();
        n_vec++;
        if (overflow !== 1'b1 || count !== 5'd16) begin
            n_err++;
            $display("FAIL coll_set_wins: got o=%b c=%0d, want o=1 c=16", overflow, count);
        end
        in_valid = 1'b0;
        tick();
        clr_ovf = 1'b0;
        n_vec++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL coll_clear: got o=%b, want 0", overflow);
        end
        in_valid = 1'b1;
        in_data  = 16'h0099;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
        end
        out_ready = 1'b0;
        n_vec++;
        if (count !== 5'd7 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset: got c=%0d o=%b, want c=7 o=1", count, overflow);
        end
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if ({out_valid, empty, full, count, overflow} !== {1'b0, 1'b1, 1'b0, 5'd0, 1'b0}) begin
            n_err++;
            $display("FAIL async_reset: got v=%b e=%b f=%b c=%0d o=%b, want v=0 e=1 f=0 c=0 o=0",
                     out_valid, empty, full, count, overflow);
        end
        #1;
        reset = 1'b0;
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || count !== 5'd0) begin
            n_err++;
            $display("FAIL post_reset: got v=%b c=%0d, want v=0 c=0", out_valid, count);
        end
        in_valid = 1'b1;
        in_data  = 16'h0C0D;
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (out_data !== 16'h0C0D || count !== 5'd1) begin
            n_err++;
            $display("FAIL post_reset_push: got d=%h c=%0d, want d=0c0d c=1", out_data, count);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_push5();
        test_pop5();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_clr_collision();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
